uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLK_FRE, default 50, system clock frequency in MHz.
REQ-002 SHALL have parameter UART_RATE, default 115200, baud rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-006 SHALL have parameter SYNC_STAGES, default 2, synchroniser flops on i_rx_pin; legal range 2..4.
REQ-007 SHALL have port i_sys_clk, input, 1, the single system clock; all logic on its rising edge.
REQ-008 SHALL have port i_sys_rst, input, 1, reset; synchronous and active-high.
REQ-009 SHALL have port i_rx_pin, input, 1, asynchronous serial line; idles high.
REQ-010 SHALL have port o_recv_en, output, 1, one-cycle pulse when a frame completes.
REQ-011 SHALL have port o_recv_data, output, DATA_BITS, last received data word, LSB first on line.
REQ-012 SHALL have port o_parity_err, output, 1, parity status of last frame; valid with o_recv_en.
REQ-013 SHALL have port o_frame_err, output, 1, stop-bit status of last frame; valid with o_recv_en.
REQ-014 SHALL have port o_busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-015 SHALL compute RATE_CNT = CLK_FRE*1_000_000/UART_RATE - 1 using integer division; bit counter width SHALL be $clog2(RATE_CNT+1).
REQ-016 SHALL pass i_rx_pin through SYNC_STAGES flops; only the last stage (rx_s) feeds the FSM.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-018 IDLE: clk_cnt held 0; rx_s==0 -> START.
REQ-019 START: count to RATE_CNT/2; at that cycle, rx_s==1 -> IDLE (glitch rejected, no pulse), rx_s==0 -> DATA with clk_cnt=0, bit_cnt=0.
REQ-020 DATA: at clk_cnt==RATE_CNT sample rx_s into shift bit bit_cnt, clear clk_cnt; after DATA_BITS samples -> PARITY if PARITY!=0, else STOP.
REQ-021 PARITY: at clk_cnt==RATE_CNT sample parity bit; error if (XOR of data ^ parity bit) differs from 1 for odd, 0 for even.
REQ-022 PARITY==0 SHALL force o_parity_err to 0.
REQ-023 STOP: at each clk_cnt==RATE_CNT sample one stop bit; any low stop bit sets frame error.
REQ-024 On the edge sampling the final stop bit: o_recv_data, o_parity_err, o_frame_err SHALL update and o_recv_en SHALL be high for exactly the next cycle.
REQ-025 After the final stop sample: stop bit high -> IDLE immediately (mid stop bit), enabling back-to-back frames; stop bit low -> BREAK.
REQ-026 BREAK: wait until rx_s==1, then IDLE; no further o_recv_en while line is low.
REQ-027 o_recv_data and error flags SHALL hold between frames; only o_recv_en pulses.
REQ-028 Input-to-pulse latency SHALL be SYNC_STAGES cycles plus frame sampling time; no other pipeline stages.

Reset
REQ-029 i_sys_rst high SHALL, on the next edge, force state IDLE, counters 0, synchroniser flops 1, o_recv_en 0, o_recv_data 0, o_parity_err 0, o_frame_err 0, o_busy 0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no pulse; reception resumes at the next falling edge after release.

Verification (CLK_FRE=50, UART_RATE=115200, RATE_CNT=433)
REQ-031 8N1 frame 0xA5 -> one o_recv_en pulse, o_recv_data=0xA5, both error flags 0.
REQ-032 DATA_BITS=8, PARITY=2, frame 0x3C with parity bit 1 -> o_recv_data=0x3C, o_parity_err=1; repeat with parity 0 -> o_parity_err=0.
REQ-033 8N1 frame 0x55 with stop bit held low 3 bit times -> pulse with o_frame_err=1, FSM in BREAK until line high, no second pulse.
REQ-034 Low glitch of 100 cycles on idle line -> no o_recv_en, o_busy returns 0 within 220 cycles.
REQ-035 Back-to-back 8N1 frames 0x00 then 0xFF with no idle gap -> two pulses, data 0x00 then 0xFF, no errors.
REQ-036 Reset asserted during bit 4 of a frame, then frame 0x81 sent -> only one pulse, o_recv_data=0x81.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchronised line input, mid-bit sampling,
// optional parity and one or two stop bits, with break detection.
module uart_rx_cfg #(
  parameter int CLK_FRE     = 50,
  parameter int UART_RATE   = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_sys_clk,
  input  logic                 i_sys_rst,
  input  logic                 i_rx_pin,
  output logic                 o_recv_en,
  output logic [DATA_BITS-1:0] o_recv_data,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int RATE_CNT = CLK_FRE * 1_000_000 / UART_RATE - 1;
  localparam int CNT_W    = $clog2(RATE_CNT + 1);
  localparam int BIT_W    = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] RATE_MAX  = CNT_W'(RATE_CNT);
  localparam logic [CNT_W-1:0] HALF_MAX  = CNT_W'(RATE_CNT / 2);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 rx_s;
  logic [DATA_BITS-1:0] shift_q;
  logic                 perr_q, ferr_q;
  logic                 data_smp, par_smp, stop_smp, frame_done;
  logic                 rate_tick;

  function automatic logic parity_error(input logic [DATA_BITS-1:0] data,
                                        input logic pbit);
    logic x;
    x = (^data) ^ pbit;
    if (PARITY == 1) return ~x;
    if (PARITY == 2) return x;
    return 1'b0;
  endfunction

  // Synchroniser: the line idles high, so reset fills the chain with ones
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) sync_q <= '1;
    else           sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx_pin};
  end
  assign rx_s = sync_q[SYNC_STAGES-1];

  assign rate_tick = (clk_cnt_q == RATE_MAX);

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q + CNT_W'(1);
    bit_cnt_d  = bit_cnt_q;
    data_smp   = 1'b0;
    par_smp    = 1'b0;
    stop_smp   = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      // Half a bit into the start bit: a high line means it was a glitch
      S_START: begin
        if (clk_cnt_q == HALF_MAX) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rate_tick) begin
          clk_cnt_d = '0;
          data_smp  = 1'b1;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (rate_tick) begin
          clk_cnt_d = '0;
          par_smp   = 1'b1;
          state_d   = S_STOP;
        end
      end
      // Leave mid stop bit so a following start edge is not missed
      S_STOP: begin
        if (rate_tick) begin
          clk_cnt_d = '0;
          stop_smp  = 1'b1;
          if (bit_cnt_q == LAST_STOP) begin
            frame_done = 1'b1;
            state_d    = rx_s ? S_IDLE : S_BREAK;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      S_BREAK: begin
        clk_cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state_q != S_IDLE);
  end

  always_ff @(posedge i_sys_clk) begin
    if (data_smp) shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
    if (state_q == S_START) begin
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end
    if (par_smp) perr_q <= parity_error(shift_q, rx_s);
    if (stop_smp && !rx_s) ferr_q <= 1'b1;
  end

  // Result registers hold between frames; only the strobe pulses
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      o_recv_en    <= 1'b0;
      o_recv_data  <= '0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_recv_en <= frame_done;
      if (frame_done) begin
        o_recv_data  <= shift_q;
        o_parity_err <= (PARITY != 0) & perr_q;
        o_frame_err  <= ferr_q | ~rx_s;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 and an 8E1 receiver driven with directed
// and random frames, results compared against a frame-level model.
module tb_uart_rx_cfg;

  localparam int BIT = 50 * 1_000_000 / 115200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx0 = 1'b1;
  logic rx1 = 1'b1;

  logic       en0, en1, perr0, perr1, ferr0, ferr1, busy0, busy1;
  logic [7:0] data0, data1;

  int checks = 0;
  int errors = 0;

  logic [9:0] q0[$];
  logic [9:0] q1[$];

  always #10 clk = ~clk;

  uart_rx_cfg u_dut (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_rx_pin(rx0),
    .o_recv_en(en0), .o_recv_data(data0), .o_parity_err(perr0),
    .o_frame_err(ferr0), .o_busy(busy0)
  );

  uart_rx_cfg #(.PARITY(2)) u_dut_p (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_rx_pin(rx1),
    .o_recv_en(en1), .o_recv_data(data1), .o_parity_err(perr1),
    .o_frame_err(ferr1), .o_busy(busy1)
  );

  always @(negedge clk) begin
    if (en0 === 1'b1) q0.push_back({ferr0, perr0, data0});
    if (en1 === 1'b1) q1.push_back({ferr1, perr1, data1});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Frame-level reference: parity error and frame error from the line contents
  function automatic logic model_perr(input logic [7:0] d, input int mode, input logic pbit);
    int ones;
    ones = $countones(d) + int'(pbit);
    if (mode == 0) return 1'b0;
    if (mode == 1) return (ones % 2) != 1;
    return (ones % 2) != 0;
  endfunction

  task automatic drive(input int line, input logic v, input int n);
    if (line == 0) rx0 = v;
    else           rx1 = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int line, input logic [7:0] d, input bit par_en,
                            input logic pbit, input logic stop_lvl, input int stop_len);
    drive(line, 1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(line, d[i], BIT);
    if (par_en) drive(line, pbit, BIT);
    drive(line, stop_lvl, stop_len);
  endtask

  task automatic expect_frame(input int line, input string tag, input logic [7:0] d,
                              input logic pe, input logic fe);
    int n;
    logic [9:0] e;
    n = (line == 0) ? q0.size() : q1.size();
    check({tag, ".pulses"}, n, 1);
    if (n > 0) begin
      if (line == 0) e = q0.pop_front();
      else           e = q1.pop_front();
      check({tag, ".data"}, {24'd0, e[7:0]}, {24'd0, d});
      check({tag, ".perr"}, {31'd0, e[8]}, {31'd0, pe});
      check({tag, ".ferr"}, {31'd0, e[9]}, {31'd0, fe});
    end
    if (line == 0) q0.delete();
    else           q1.delete();
  endtask

  initial begin
    logic [7:0] d;
    logic       pb;
    logic [9:0] e;

    // Reset state
    repeat (4) @(negedge clk);
    check("rst.busy0", {31'd0, busy0}, 0);
    check("rst.en0", {31'd0, en0}, 0);
    check("rst.data0", {24'd0, data0}, 0);
    check("rst.perr0", {31'd0, perr0}, 0);
    check("rst.ferr0", {31'd0, ferr0}, 0);
    check("rst.busy1", {31'd0, busy1}, 0);
    check("rst.data1", {24'd0, data1}, 0);
    rst = 1'b0;
    drive(0, 1'b1, 2 * BIT);

    // Basic 8N1 frame
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, BIT);
    drive(0, 1'b1, BIT);
    expect_frame(0, "a5", 8'hA5, 1'b0, 1'b0);
    check("a5.hold", {24'd0, data0}, 32'hA5);

    // Even parity: wrong and right parity bit
    send_frame(1, 8'h3C, 1'b1, 1'b1, 1'b1, BIT);
    drive(1, 1'b1, BIT);
    expect_frame(1, "p3c_bad", 8'h3C, model_perr(8'h3C, 2, 1'b1), 1'b0);
    send_frame(1, 8'h3C, 1'b1, 1'b0, 1'b1, BIT);
    drive(1, 1'b1, BIT);
    expect_frame(1, "p3c_ok", 8'h3C, model_perr(8'h3C, 2, 1'b0), 1'b0);

    // Random frames against the model
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(0, d, 1'b0, 1'b0, 1'b1, BIT);
      drive(0, 1'b1, BIT / 2 + int'($urandom_range(0, BIT)));
      expect_frame(0, "rnd8n1", d, model_perr(d, 0, 1'b0), 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      d  = 8'($urandom_range(0, 255));
      pb = 1'($urandom_range(0, 1));
      send_frame(1, d, 1'b1, pb, 1'b1, BIT);
      drive(1, 1'b1, BIT / 2 + int'($urandom_range(0, BIT)));
      expect_frame(1, "rnd8e1", d, model_perr(d, 2, pb), 1'b0);
    end

    // Stop bit held low: frame error, then break until the line recovers
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, 3 * BIT);
    check("brk.busy", {31'd0, busy0}, 1);
    expect_frame(0, "brk", 8'h55, 1'b0, 1'b1);
    drive(0, 1'b1, 10);
    check("brk.idle", {31'd0, busy0}, 0);
    drive(0, 1'b1, 2 * BIT);
    check("brk.nopulse", q0.size(), 0);

    // Short low glitch on the idle line
    rx0 = 1'b0;
    for (int i = 1; i <= 220; i++) begin
      @(negedge clk);
      if (i == 50) check("glitch.busy", {31'd0, busy0}, 1);
      if (i == 100) rx0 = 1'b1;
    end
    check("glitch.idle", {31'd0, busy0}, 0);
    drive(0, 1'b1, BIT);
    check("glitch.nopulse", q0.size(), 0);

    // Back-to-back frames with no idle gap
    send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1, BIT);
    send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1, BIT);
    drive(0, 1'b1, BIT);
    check("b2b.pulses", q0.size(), 2);
    if (q0.size() == 2) begin
      e = q0.pop_front();
      check("b2b.first", {22'd0, e}, {22'd0, 2'b00, 8'h00});
      e = q0.pop_front();
      check("b2b.second", {22'd0, e}, {22'd0, 2'b00, 8'hFF});
    end
    q0.delete();

    // Reset in the middle of bit 4 abandons the frame
    drive(0, 1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(0, 1'b0, BIT);
    drive(0, 1'b0, BIT / 2);
    rx0 = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("midrst.busy", {31'd0, busy0}, 0);
    check("midrst.data", {24'd0, data0}, 0);
    drive(0, 1'b1, 2 * BIT);
    check("midrst.nopulse", q0.size(), 0);
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1, BIT);
    drive(0, 1'b1, BIT);
    expect_frame(0, "after_rst", 8'h81, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
